// File: rtl/mod_counter.sv
// Parametrised up/down modulus counter with load, wrap-or-saturate mode, tc/wrap/sat flags.
// Optional compare-match pulse is built only when MOD_COUNTER_MATCH_EN is defined.
module mod_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MAX_VAL  = (longint'(1) << WIDTH) - 1,
  parameter bit     SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
`ifdef MOD_COUNTER_MATCH_EN
  input  logic [WIDTH-1:0] cmp_val,
  output logic             match,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH must be in 2..32");
  end
  if (MAX_VAL < 1 || MAX_VAL > (longint'(1) << WIDTH) - 1) begin : g_bad_max
    $error("mod_counter: MAX_VAL must be in 1..2**WIDTH-1");
  end

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return ({1'b0, v} > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : v;
  endfunction

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat;

  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_nxt;
  logic             w_sat_nxt;
  logic             w_upd;

  // One extra bit keeps count+1 at 2**WIDTH-1 and count-1 at 0 from aliasing.
  assign w_cnt_ext = {1'b0, r_count};
  assign w_inc     = w_cnt_ext + ONE_EXT;
  assign w_dec     = w_cnt_ext - ONE_EXT;
  assign w_at_max  = (w_inc > MAX_EXT);
  assign w_at_zero = w_dec[WIDTH];

  always_comb begin
    w_next     = r_count;
    w_wrap_nxt = 1'b0;
    w_sat_nxt  = r_sat;
    w_upd      = 1'b0;
    if (load) begin
      w_next    = clamp_load(load_val);
      w_sat_nxt = 1'b0;
      w_upd     = 1'b1;
    end else if (en) begin
      if (up_dn) begin
        if (!w_at_max) begin
          w_next = w_inc[WIDTH-1:0];
          w_upd  = 1'b1;
        end else if (SATURATE) begin
          w_sat_nxt = 1'b1;
        end else begin
          w_next     = '0;
          w_wrap_nxt = 1'b1;
          w_upd      = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_next = w_dec[WIDTH-1:0];
          w_upd  = 1'b1;
        end else if (SATURATE) begin
          w_sat_nxt = 1'b1;
        end else begin
          w_next     = MAX_EXT[WIDTH-1:0];
          w_wrap_nxt = 1'b1;
          w_upd      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_wrap_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

`ifdef MOD_COUNTER_MATCH_EN
  logic r_upd;
  logic r_match;

  // Match fires one cycle after a real update lands on cmp_val; holds never re-fire it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd   <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_upd   <= w_upd;
      r_match <= r_upd && (r_count == cmp_val);
    end
  end

  assign match = r_match;
`else
  logic w_upd_unused;
  assign w_upd_unused = w_upd;
`endif

  assign count = r_count;
  assign wrap  = r_wrap;
  assign sat   = r_sat;
  assign tc    = en & ((up_dn & w_at_max) | (~up_dn & w_at_zero));

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three parameter sets driven in parallel, table vectors,
// directed corner sequences and random stimulus against a modular-arithmetic model.
module tb_mod_counter;

  logic       clk;
  logic       rst, en, load, up_dn;
  logic [3:0] load_val;
  logic [3:0] cmp_val;

  logic [3:0] c15, c9, cs;
  logic       tc15, tc9, tcs;
  logic       w15, w9, ws;
  logic       s15, s9, ss;
`ifdef MOD_COUNTER_MATCH_EN
  logic       mt15, mt9, mts;
`endif

  int total = 0;
  int bad   = 0;

  mod_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) d15 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .up_dn(up_dn),
`ifdef MOD_COUNTER_MATCH_EN
    .cmp_val(cmp_val), .match(mt15),
`endif
    .count(c15), .tc(tc15), .wrap(w15), .sat(s15));

  mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) d9 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .up_dn(up_dn),
`ifdef MOD_COUNTER_MATCH_EN
    .cmp_val(cmp_val), .match(mt9),
`endif
    .count(c9), .tc(tc9), .wrap(w9), .sat(s9));

  mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dsat (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .up_dn(up_dn),
`ifdef MOD_COUNTER_MATCH_EN
    .cmp_val(cmp_val), .match(mts),
`endif
    .count(cs), .tc(tcs), .wrap(ws), .sat(ss));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int c; bit w; bit s; } mst_t;

  mst_t m15, m9, ms;
  bit   mdl_ok = 1'b0;

  // Reference: counting is arithmetic modulo (maxv+1), or clamped to [0,maxv].
  function automatic mst_t step(mst_t m, int maxv, bit satm,
                                bit r, bit e, bit l, int lv, bit u);
    mst_t n;
    n   = m;
    n.w = 1'b0;
    if (r) begin
      n.c = 0; n.s = 1'b0;
    end else if (l) begin
      n.c = (lv > maxv) ? maxv : lv;
      n.s = 1'b0;
    end else if (e) begin
      if (satm) begin
        if (u) begin
          if (m.c == maxv) n.s = 1'b1; else n.c = m.c + 1;
        end else begin
          if (m.c == 0) n.s = 1'b1; else n.c = m.c - 1;
        end
      end else begin
        n.c = u ? (m.c + 1) % (maxv + 1) : (m.c + maxv) % (maxv + 1);
        n.w = u ? (m.c == maxv) : (m.c == 0);
      end
    end
    return n;
  endfunction

  function automatic bit mtc(mst_t m, int maxv, bit e, bit u);
    return e && ((u && m.c == maxv) || (!u && m.c == 0));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_dut(input string p, input mst_t m,
                         input logic [3:0] c, input logic w, input logic s);
    chk({p, ".count"}, 32'(c), 32'(m.c));
    chk({p, ".wrap"},  32'(w), 32'(m.w));
    chk({p, ".sat"},   32'(s), 32'(m.s));
  endtask

  // Entered at a falling edge; drives inputs, checks tc, clocks once, checks registers.
  task automatic apply(input bit r, input bit e, input bit l, input logic [3:0] lv,
                       input bit u, output logic tc9_pre);
    rst = r; en = e; load = l; load_val = lv; up_dn = u;
    #1;
    tc9_pre = tc9;
    if (mdl_ok) begin
      chk("d15.tc", 32'(tc15), 32'(mtc(m15, 15, e, u)));
      chk("d9.tc",  32'(tc9),  32'(mtc(m9, 9, e, u)));
      chk("ds.tc",  32'(tcs),  32'(mtc(ms, 9, e, u)));
    end
    @(posedge clk);
    m15 = step(m15, 15, 1'b0, r, e, l, int'(lv), u);
    m9  = step(m9,  9,  1'b0, r, e, l, int'(lv), u);
    ms  = step(ms,  9,  1'b1, r, e, l, int'(lv), u);
    if (r) mdl_ok = 1'b1;
    @(negedge clk);
    if (mdl_ok) begin
      chk_dut("d15", m15, c15, w15, s15);
      chk_dut("d9",  m9,  c9,  w9,  s9);
      chk_dut("ds",  ms,  cs,  ws,  ss);
    end
  endtask

  typedef struct {
    bit r; bit e; bit l; logic [3:0] lv; bit u;
    int c; bit w; bit s; bit tc;
  } vec_t;

  vec_t tbl[14];
  int   upseq[12];
  logic tcp;
  bit   seen;

  initial begin
    // Expectations for the MAX_VAL=9 wrapping instance.
    tbl[0]  = '{1, 1, 1, 4'd5,  1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 4'd5,  1, 5, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 4'd13, 1, 9, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 4'd0,  0, 8, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 4'd0,  0, 7, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 4'd0,  0, 6, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 4'd0,  0, 5, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 4'd0,  0, 4, 0, 0, 0};
    tbl[8]  = '{0, 1, 0, 4'd0,  0, 3, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 4'd0,  0, 2, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 4'd0,  0, 1, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 4'd0,  0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 4'd0,  0, 9, 1, 0, 1};
    tbl[13] = '{0, 1, 0, 4'd0,  0, 8, 0, 0, 0};
    upseq   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'd0; up_dn = 1'b1; cmp_val = 4'd7;
    m15 = '{0, 0, 0}; m9 = '{0, 0, 0}; ms = '{0, 0, 0};
    @(negedge clk);

    // Legacy free-running count on the full-range instance.
    apply(1, 0, 0, 4'd0, 1, tcp);
    apply(1, 0, 0, 4'd0, 1, tcp);
    chk("reset.count", 32'(c15), 32'd0);
    chk("reset.wrap",  32'(w15), 32'd0);
    chk("reset.sat",   32'(ss),  32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      apply(0, 1, 0, 4'd0, 1, tcp);
      seen |= w15;
    end
    chk("legacy.count",  32'(c15), 32'd10);
    chk("legacy.nowrap", 32'(seen), 32'd0);

    // Priority, clamped load and down-count wrap.
    apply(1, 0, 0, 4'd0, 1, tcp);
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].lv, tbl[i].u, tcp);
      chk($sformatf("tbl%0d.count", i), 32'(c9),  32'(tbl[i].c));
      chk($sformatf("tbl%0d.wrap",  i), 32'(w9),  32'(tbl[i].w));
      chk($sformatf("tbl%0d.sat",   i), 32'(s9),  32'(tbl[i].s));
      chk($sformatf("tbl%0d.tc",    i), 32'(tcp), 32'(tbl[i].tc));
    end

    // Up-count wrap at MAX_VAL=9.
    apply(0, 0, 1, 4'd0, 1, tcp);
    for (int i = 0; i < 12; i++) begin
      apply(0, 1, 0, 4'd0, 1, tcp);
      chk($sformatf("up%0d.tc", i),    32'(tcp), 32'(i == 9));
      chk($sformatf("up%0d.count", i), 32'(c9),  32'(upseq[i]));
      chk($sformatf("up%0d.wrap", i),  32'(w9),  32'(i == 9));
    end

    // Saturation at the top, then cleared by load.
    apply(1, 0, 0, 4'd0, 1, tcp);
    for (int i = 1; i <= 15; i++) begin
      apply(0, 1, 0, 4'd0, 1, tcp);
      chk($sformatf("sat%0d.count", i), 32'(cs), 32'((i < 9) ? i : 9));
      chk($sformatf("sat%0d.sat", i),   32'(ss), 32'(i >= 10));
      chk($sformatf("sat%0d.wrap", i),  32'(ws), 32'd0);
    end
    apply(0, 0, 1, 4'd3, 1, tcp);
    chk("satload.count", 32'(cs), 32'd3);
    chk("satload.sat",   32'(ss), 32'd0);

    // Saturation at the bottom.
    apply(0, 0, 1, 4'd1, 0, tcp);
    apply(0, 1, 0, 4'd0, 0, tcp);
    apply(0, 1, 0, 4'd0, 0, tcp);
    chk("satlo.count", 32'(cs), 32'd0);
    chk("satlo.sat",   32'(ss), 32'd1);

`ifdef MOD_COUNTER_MATCH_EN
    apply(1, 0, 0, 4'd0, 1, tcp);
    cmp_val = 4'd7;
    for (int i = 1; i <= 7; i++) begin
      apply(0, 1, 0, 4'd0, 1, tcp);
      chk($sformatf("match.up%0d", i), 32'(mt9), 32'd0);
    end
    for (int j = 0; j < 4; j++) begin
      apply(0, 0, 0, 4'd0, 1, tcp);
      chk($sformatf("match.hold%0d", j), 32'(mt9), 32'(j == 0));
    end
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(31) == 0), ($urandom_range(3) != 0), ($urandom_range(7) == 0),
            4'($urandom_range(15)), 1'($urandom_range(1)), tcp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
